// File: rtl/stack_cmd_seq.sv
// stack_cmd_seq: command sequencer that drives the stackcalc shift register
// (d/en/dir/rst). It accepts LOAD (MSB-first serialisation), SHR (logical
// right shift by N, clamped to WIDTH) and CLEAR/NOP, one per handshake, and
// pulses done once the shift register contents are final.
// Optional feature macro: LOADER_VERIFY_EN adds a CHECK state after LOAD that
// compares sr_q against the loaded word and sets a sticky err on mismatch.
module stack_cmd_seq #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CW-1:0]    cmd_amt,
    output logic             sr_d,
    output logic             sr_en,
    output logic             sr_dir,
    output logic             sr_rst,
    input  logic [WIDTH-1:0] sr_q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_CLR,
        S_NOP
`ifdef LOADER_VERIFY_EN
        , S_CHECK
`endif
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_data;
    logic [CW-1:0]    r_amt;
    logic             r_done;

    logic [CW-1:0]    w_amt_clamp;
    logic             w_load_last;
    logic             w_shift_last;
    logic [WIDTH-1:0] w_ser;

    // SHR distances beyond the register width all give an empty register
    assign w_amt_clamp  = (cmd_amt > CW'(WIDTH)) ? CW'(WIDTH) : cmd_amt;
    assign w_load_last  = (r_cnt == CW'(WIDTH - 1));
    assign w_shift_last = (r_amt == '0) || (r_cnt == (r_amt - CW'(1)));
    // Bit data[WIDTH-1-cnt] lands in the MSB, avoiding an oversized index
    assign w_ser        = r_data << r_cnt;

`ifdef LOADER_VERIFY_EN
    logic r_err;
    assign err = r_err;
`else
    logic w_unused_q;
    assign w_unused_q = ^sr_q;
    assign err        = 1'b0;
`endif

    // Moore output decode from registered state/cnt; sr_rst also follows rst
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = !cmd_ready;
    assign sr_en     = (r_state == S_LOAD) || ((r_state == S_SHIFT) && (r_amt != '0));
    assign sr_dir    = (r_state == S_SHIFT);
    assign sr_d      = (r_state == S_LOAD) && w_ser[WIDTH-1];
    assign sr_rst    = rst || (r_state == S_CLR);
    assign done      = r_done;

    // Sequencer FSM: handshake, per-op cycle counting, done pulse generation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_amt   <= '0;
            r_done  <= 1'b0;
`ifdef LOADER_VERIFY_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cnt  <= '0;
                        r_data <= cmd_data;
                        r_amt  <= w_amt_clamp;
                        case (cmd_op)
                            2'b01:   r_state <= S_LOAD;
                            2'b10:   r_state <= S_SHIFT;
                            2'b11:   r_state <= S_CLR;
                            default: r_state <= S_NOP;
                        endcase
                    end
                end
                S_LOAD: begin
                    if (w_load_last) begin
                        r_cnt <= '0;
`ifdef LOADER_VERIFY_EN
                        r_state <= S_CHECK;
`else
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_SHIFT: begin
                    if (w_shift_last) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_CLR: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
`ifdef LOADER_VERIFY_EN
                    r_err   <= 1'b0;
`endif
                end
`ifdef LOADER_VERIFY_EN
                S_CHECK: begin
                    if (sr_q != r_data) r_err <= 1'b1;
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_cmd_seq.sv
// tb_stack_cmd_seq: scoreboard bench for stack_cmd_seq with a behavioural
// shift register attached. Stimulus pushes expected results; a negedge
// monitor pops and compares them on every done pulse.
module tb_stack_cmd_seq;

    localparam int W  = 8;
    localparam int CW = 4;
`ifdef LOADER_VERIFY_EN
    localparam int LAT_LOAD = W + 1;
`else
    localparam int LAT_LOAD = W;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [W-1:0]  cmd_data;
    logic [CW-1:0] cmd_amt;
    logic          sr_d, sr_en, sr_dir, sr_rst;
    logic [W-1:0]  sr_q_m;
    logic [W-1:0]  flip;
    logic [W-1:0]  sr_q;
    logic          busy, done, err;

    always #5 clk = ~clk;

    assign sr_q = sr_q_m ^ flip;

    stack_cmd_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_amt(cmd_amt),
        .sr_d(sr_d), .sr_en(sr_en), .sr_dir(sr_dir), .sr_rst(sr_rst),
        .sr_q(sr_q), .busy(busy), .done(done), .err(err)
    );

    // Downstream shift register (plant)
    always @(posedge clk) begin
        if (sr_rst)      sr_q_m <= '0;
        else if (sr_en)  sr_q_m <= sr_dir ? (sr_q_m >> 1) : {sr_q_m[W-2:0], sr_d};
    end

    typedef struct {
        logic [W-1:0] q;
        int           lat;
        int           en;
        logic         chk_ser;
        logic [W-1:0] ser;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    logic [W-1:0] q_ref;
    logic         err_ref;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: counts enables, captures serial bits, scores each done pulse
    int           hs_cyc = 0;
    int           en_cnt = 0;
    logic [W-1:0] ser_cap = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b1) begin
            if (sr_en) en_cnt++;
            if (sr_en && !sr_dir) ser_cap = {ser_cap[W-2:0], sr_d};
            if (cmd_ready && sr_en) begin
                mismatched++;
                $display("FAIL idle_en: sr_en=1 while cmd_ready=1 (t=%0t)", $time);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_done: done=1 with nothing outstanding (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    chk("sr_q", 32'(sr_q_m), 32'(e.q));
                    chk("latency", 32'(cyc - hs_cyc), 32'(e.lat));
                    chk("en_cycles", 32'(en_cnt), 32'(e.en));
                    if (e.chk_ser) chk("serial_bits", 32'(ser_cap), 32'(e.ser));
                    chk("err", 32'(err), 32'(e.err));
                    chk("ready_in_done", 32'(cmd_ready), 32'd1);
                end
            end
            if (cmd_valid && cmd_ready) begin
                hs_cyc  = cyc + 1;
                en_cnt  = 0;
                ser_cap = '0;
            end
        end
    end

    task automatic handshake(input logic [1:0] op, input logic [W-1:0] d, input logic [CW-1:0] a,
                             output bit ok);
        ok        = 1'b0;
        cmd_op    = op;
        cmd_data  = d;
        cmd_amt   = a;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (!ok) begin
            mismatched++;
            $display("FAIL handshake_timeout: cmd_ready never 1, expected 1 (t=%0t)", $time);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] d, input int amt, input int gap);
        exp_t e;
        int   n;
        bit   ok;
        e.chk_ser = 1'b0;
        e.ser     = '0;
        case (op)
            2'b01: begin
                q_ref = d;
                if (flip != '0) err_ref = 1'b1;
                e.lat = LAT_LOAD; e.en = W; e.chk_ser = 1'b1; e.ser = d;
            end
            2'b10: begin
                n = (amt > W) ? W : amt;
                q_ref = (n >= W) ? '0 : (q_ref >> n);
                e.lat = (n == 0) ? 1 : n;
                e.en  = n;
            end
            2'b11: begin
                q_ref = '0; err_ref = 1'b0;
                e.lat = 1; e.en = 0;
            end
            default: begin
                e.lat = 1; e.en = 0;
            end
        endcase
        e.q   = q_ref;
        e.err = err_ref;
        sb.push_back(e);
        handshake(op, d, CW'(amt), ok);
        if (!ok) void'(sb.pop_back());
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain_timeout: %0d outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_amt = '0;
        flip = '0; q_ref = '0; err_ref = 1'b0;

        // Reset behaviour
        @(negedge clk); chk("sr_rst_in_rst_c1", 32'(sr_rst), 32'd1);
        @(negedge clk); chk("sr_rst_in_rst_c2", 32'(sr_rst), 32'd1);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sr_en", 32'(sr_en), 32'd0);
        chk("rst_sr_rst", 32'(sr_rst), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_plant_q", 32'(sr_q_m), 32'd0);
        @(posedge clk); #1;

        // Directed: load, back-to-back load/shift, clamp, zero shift
        send(2'b01, 8'hA5, 0, 1);
        send(2'b01, 8'hF0, 0, 0);
        send(2'b10, 8'h00, 3, 0);
        send(2'b10, 8'h00, 15, 0);
        send(2'b01, 8'h77, 0, 0);
        send(2'b10, 8'h00, 0, 0);
        send(2'b00, 8'h00, 0, 0);
        send(2'b10, 8'h00, 8, 1);
        wait_idle();

        // Reset mid-LOAD aborts without done
        handshake(2'b01, 8'hFF, '0, ok);
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_plant_q", 32'(sr_q_m), 32'd0);
        q_ref = '0; err_ref = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        send(2'b01, 8'h3C, 0, 1);
        wait_idle();

        // Randomized command stream
        for (int i = 0; i < 40; i++) begin
            send(2'($urandom_range(0, 3)), W'($urandom), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 2)));
        end
        wait_idle();

`ifdef LOADER_VERIFY_EN
        // Corrupted readback sets sticky err; CLEAR removes it
        flip = 8'h01;
        send(2'b01, 8'h5A, 0, 0);
        wait_idle();
        flip = '0;
        send(2'b01, 8'h12, 0, 0);
        send(2'b10, 8'h00, 2, 0);
        send(2'b11, 8'h00, 0, 0);
        send(2'b01, 8'hC3, 0, 0);
        wait_idle();
`endif

        send(2'b11, 8'h00, 0, 0);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
